vector_register_file_param: RTL and testbench

- Parametrised next-generation vector register file: NUM_LANES x LANE_WIDTH lanes, NUM_STRANDS strands of REGS_PER_STRAND registers each.
- Provides two registered read ports and one lane-masked write port.
- Adds same-cycle write-to-read bypass.
- Adds a multi-cycle strand-clear sequencer, so storage can be zeroed without a synthesis-only initialiser.
- Sits between the instruction issue stage (read selects) and the writeback stage (write port) of the vector pipeline.

---
 rtl/vector_register_file_param.sv | 146 ++++++++++++++
 tb/tb_vector_register_file_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_register_file_param.sv
`default_nettype none
// ============================================================================
// vector_register_file_param : lane-masked vector register file, two registered
// read ports with write bypass, multi-cycle strand-clear sequencer.  Rev 1.0
// ============================================================================
module vector_register_file_param #(
  parameter  int NUM_LANES       = 16,
  parameter  int LANE_WIDTH      = 32,
  parameter  int NUM_STRANDS     = 4,
  parameter  int REGS_PER_STRAND = 32,
  localparam int DEPTH           = NUM_STRANDS * REGS_PER_STRAND,
  localparam int IDX_W           = $clog2(DEPTH),
  localparam int STRAND_W        = $clog2(NUM_STRANDS),
  localparam int VEC_W           = NUM_LANES * LANE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [IDX_W-1:0]       sel1_i,
  input  logic [IDX_W-1:0]       sel2_i,
  output logic [VEC_W-1:0]       value1_o,
  output logic [VEC_W-1:0]       value2_o,
  input  logic [IDX_W-1:0]       write_reg_i,
  input  logic [VEC_W-1:0]       write_value_i,
  input  logic [NUM_LANES-1:0]   write_mask_i,
  input  logic                   write_en_i,
  input  logic                   clear_req_i,
  input  logic [STRAND_W-1:0]    clear_strand_i,
  output logic                   clear_busy_o,
  output logic                   clear_done_o
);

  localparam int               CNT_W    = $clog2(REGS_PER_STRAND);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REGS_PER_STRAND - 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    clr_cnt, clr_cnt_next;
  logic [STRAND_W-1:0] clr_strand, clr_strand_next;
  logic                done_next;

  // Clear sequencer: an external write always wins the single write port,
  // which simply stalls the counter for that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      clr_strand   <= '0;
      clear_done_o <= 1'b0;
    end else begin
      state        <= state_next;
      clr_cnt      <= clr_cnt_next;
      clr_strand   <= clr_strand_next;
      clear_done_o <= done_next;
    end
  end

  always_comb begin
    state_next      = state;
    clr_cnt_next    = clr_cnt;
    clr_strand_next = clr_strand;
    done_next       = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req_i) begin
          state_next      = CLEARING;
          clr_cnt_next    = '0;
          clr_strand_next = clear_strand_i;
        end
      end
      CLEARING: begin
        if (!write_en_i) begin
          clr_cnt_next = clr_cnt + CNT_W'(1);
          if (clr_cnt == CNT_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clear_busy_o = (state == CLEARING);

  // Effective write: external, clear, or none.
  logic                 wr_valid;
  logic [IDX_W-1:0]     wr_idx;
  logic [VEC_W-1:0]     wr_data;
  logic [NUM_LANES-1:0] wr_mask;

  always_comb begin
    wr_valid = 1'b0;
    wr_idx   = write_reg_i;
    wr_data  = write_value_i;
    wr_mask  = write_mask_i;
    if (write_en_i) begin
      wr_valid = 1'b1;
    end else if (state == CLEARING) begin
      wr_valid = 1'b1;
      wr_idx   = {clr_strand, clr_cnt};
      wr_data  = '0;
      wr_mask  = '1;
    end
  end

  logic [VEC_W-1:0] rd1_next, rd2_next;

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [LANE_WIDTH-1:0] mem [DEPTH];
      logic                  lane_we;
      logic [LANE_WIDTH-1:0] lane_wdata;

      assign lane_we    = wr_valid && wr_mask[l];
      assign lane_wdata = wr_data[l*LANE_WIDTH +: LANE_WIDTH];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem[wr_idx] <= lane_wdata;
        end
      end

      // Bypass makes the read see the value committing on the same edge.
      assign rd1_next[l*LANE_WIDTH +: LANE_WIDTH] =
        (lane_we && (wr_idx == sel1_i)) ? lane_wdata : mem[sel1_i];
      assign rd2_next[l*LANE_WIDTH +: LANE_WIDTH] =
        (lane_we && (wr_idx == sel2_i)) ? lane_wdata : mem[sel2_i];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value1_o <= '0;
      value2_o <= '0;
    end else begin
      value1_o <= rd1_next;
      value2_o <= rd2_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_register_file_param.sv
`default_nettype none
// ============================================================================
// tb_vector_register_file_param : randomized + directed self-checking bench
// against an array-based reference model of the register file.  Rev 1.0
// ============================================================================
module tb_vector_register_file_param;

  localparam int NL    = 16;
  localparam int LW    = 32;
  localparam int NS    = 4;
  localparam int RPS   = 32;
  localparam int DEPTH = NS * RPS;
  localparam int IDX_W = 7;
  localparam int SW    = 2;
  localparam int VW    = NL * LW;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [IDX_W-1:0] sel1 = '0, sel2 = '0, write_reg = '0;
  logic [VW-1:0]    value1, value2, write_value = '0;
  logic [NL-1:0]    write_mask = '0;
  logic             write_en = 1'b0, clear_req = 1'b0;
  logic [SW-1:0]    clear_strand = '0;
  logic             clear_busy, clear_done;

  vector_register_file_param #(
    .NUM_LANES(NL), .LANE_WIDTH(LW), .NUM_STRANDS(NS), .REGS_PER_STRAND(RPS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sel1_i(sel1), .sel2_i(sel2), .value1_o(value1), .value2_o(value2),
    .write_reg_i(write_reg), .write_value_i(write_value),
    .write_mask_i(write_mask), .write_en_i(write_en),
    .clear_req_i(clear_req), .clear_strand_i(clear_strand),
    .clear_busy_o(clear_busy), .clear_done_o(clear_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: register contents plus clear progress as plain integers.
  logic [VW-1:0] model [DEPTH];
  bit  m_clearing = 1'b0;
  int  m_strand = 0;
  int  m_pos = 0;
  bit  check_reads = 1'b0;
  int  busy_cycles = 0;
  int  done_pulses = 0;

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int l = 0; l < NL; l++) v[l*LW +: LW] = $urandom | 32'h1;
    return v;
  endfunction

  // One clock edge: apply the edge's effective write to the model, then
  // reads return post-edge contents (that is what bypass guarantees).
  task automatic tick();
    logic [VW-1:0] e1, e2;
    logic [NL-1:0] wmask;
    logic [VW-1:0] wdata;
    bit  wv, ed;
    int  widx;
    wv = 1'b0; ed = 1'b0; widx = 0; wdata = '0; wmask = '0;
    if (write_en) begin
      wv = 1'b1; widx = int'(write_reg); wdata = write_value; wmask = write_mask;
    end else if (m_clearing) begin
      wv = 1'b1; widx = m_strand * RPS + m_pos; wdata = '0; wmask = '1;
    end
    if (wv)
      for (int l = 0; l < NL; l++)
        if (wmask[l]) model[widx][l*LW +: LW] = wdata[l*LW +: LW];
    if (m_clearing) begin
      if (!write_en) begin
        m_pos++;
        if (m_pos == RPS) begin
          m_clearing = 1'b0;
          ed = 1'b1;
        end
      end
    end else if (clear_req) begin
      m_clearing = 1'b1;
      m_strand   = int'(clear_strand);
      m_pos      = 0;
    end
    e1 = model[sel1];
    e2 = model[sel2];
    @(posedge clk);
    #1;
    if (check_reads) begin
      check_val("value1", value1, e1);
      check_val("value2", value2, e2);
    end
    check_val("busy", VW'(clear_busy), VW'(m_clearing));
    check_val("done", VW'(clear_done), VW'(ed));
    if (clear_busy) busy_cycles++;
    if (clear_done) done_pulses++;
  endtask

  task automatic run_until_done(input int limit);
    int n;
    n = 0;
    while (!clear_done && n < limit) begin
      sel1 = IDX_W'($urandom_range(0, DEPTH-1));
      sel2 = IDX_W'($urandom_range(0, DEPTH-1));
      tick();
      n++;
    end
    if (!clear_done) check_val("clear_timeout", VW'(clear_done), VW'(1));
  endtask

  task automatic start_clear(input int s);
    write_en = 1'b0; clear_req = 1'b1; clear_strand = SW'(s);
    busy_cycles = 0; done_pulses = 0;
    tick();
    clear_req = 1'b0;
  endtask

  task automatic fill_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      write_en = 1'b1; write_reg = IDX_W'(i); write_value = rand_vec(); write_mask = '1;
      tick();
    end
    write_en = 1'b0;
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sel1 = IDX_W'(i); sel2 = IDX_W'(hi - (i - lo));
      tick();
    end
  endtask

  logic [VW-1:0] vtmp, vexp;
  logic [VW-1:0] saved [32];

  initial begin
    // Power-on reset, released between edges.
    #1 reset_n = 1'b0;
    #10;
    check_val("rst_value1", value1, '0);
    check_val("rst_value2", value2, '0);
    check_val("rst_busy", VW'(clear_busy), '0);
    check_val("rst_done", VW'(clear_done), '0);
    #1 reset_n = 1'b1;

    // Define every register by clearing all strands.
    for (int s = 0; s < NS; s++) begin
      start_clear(s);
      run_until_done(100);
      check_val("init_busy_len", VW'(busy_cycles), VW'(RPS));
    end
    check_reads = 1'b1;

    // Masked write then read.
    write_en = 1'b1; write_reg = 7'h25; write_value = {NL{32'hA5A5A5A5}}; write_mask = 16'hFFFF;
    tick();
    write_value = {NL{32'h11111111}}; write_mask = 16'h00FF;
    tick();
    write_en = 1'b0; sel1 = 7'h25; sel2 = 7'h00;
    tick();
    check_val("masked_rd", value1, {{8{32'hA5A5A5A5}}, {8{32'h11111111}}});

    // Same-cycle bypass on both ports.
    write_en = 1'b1; write_reg = 7'h03; write_value = '0; write_mask = '1;
    tick();
    vtmp = {NL{32'h5A5A5A5A}};
    vtmp[31:0] = 32'hDEADBEEF;
    vtmp[VW-1 -: LW] = 32'hCAFEF00D;
    vexp = '0;
    vexp[31:0] = 32'hDEADBEEF;
    vexp[VW-1 -: LW] = 32'hCAFEF00D;
    sel1 = 7'h03; sel2 = 7'h03; write_value = vtmp; write_mask = 16'h8001;
    tick();
    write_en = 1'b0;
    check_val("bypass_p1", value1, vexp);
    check_val("bypass_p2", value2, vexp);

    // Zero-mask write is a no-op with no bypass.
    write_en = 1'b1; write_reg = 7'h03; write_value = rand_vec(); write_mask = '0;
    tick();
    write_en = 1'b0;
    check_val("nomask_p1", value1, vexp);

    // Clear strand 2 without stalls.
    fill_range(32, 127);
    start_clear(2);
    run_until_done(100);
    check_val("clr2_busy_len", VW'(busy_cycles), VW'(RPS));
    check_val("clr2_done_cnt", VW'(done_pulses), VW'(1));
    for (int i = 32'h40; i <= 32'h5F; i++) begin
      sel1 = IDX_W'(i); sel2 = IDX_W'(i ^ 32'h60);
      tick();
      check_val("clr2_zero", value1, '0);
    end
    read_range(32, 63);
    read_range(96, 127);

    // Clear strand 3 with five stall cycles writing strand 0.
    start_clear(3);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 5; i++) begin
      write_en = 1'b1; write_reg = IDX_W'(i * 3); write_value = rand_vec(); write_mask = '1;
      tick();
    end
    write_en = 1'b0;
    run_until_done(100);
    check_val("stall_busy_len", VW'(busy_cycles), VW'(RPS + 5));
    read_range(0, 31);
    for (int i = 32'h60; i <= 32'h7F; i++) begin
      sel1 = IDX_W'(i);
      tick();
      check_val("clr3_zero", value1, '0);
    end

    // Request during a clear is ignored.
    fill_range(0, 31);
    start_clear(1);
    for (int i = 0; i < 4; i++) tick();
    clear_req = 1'b1; clear_strand = 2'd0;
    for (int i = 0; i < 3; i++) tick();
    clear_req = 1'b0;
    run_until_done(100);
    for (int i = 0; i < 5; i++) tick();
    check_val("ign_done_cnt", VW'(done_pulses), VW'(1));
    check_val("ign_busy_len", VW'(busy_cycles), VW'(RPS));
    read_range(0, 31);

    // Reset in the middle of a clear of strand 1.
    fill_range(32, 63);
    for (int i = 0; i < 32; i++) saved[i] = model[32 + i];
    start_clear(1);
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    #2;
    check_val("mid_rst_busy", VW'(clear_busy), '0);
    check_val("mid_rst_value1", value1, '0);
    check_val("mid_rst_value2", value2, '0);
    m_clearing = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sel1 = IDX_W'(32 + i); sel2 = IDX_W'(63 - i);
      tick();
      check_val("mid_rst_data", value1, (i < 10) ? '0 : saved[i]);
    end
    check_val("mid_rst_no_done", VW'(done_pulses), '0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      sel1 = IDX_W'($urandom_range(0, DEPTH-1));
      sel2 = ($urandom_range(0, 7) == 0) ? sel1 : IDX_W'($urandom_range(0, DEPTH-1));
      write_en  = ($urandom_range(0, 1) == 1);
      write_reg = ($urandom_range(0, 3) == 0) ? sel1 : IDX_W'($urandom_range(0, DEPTH-1));
      write_value = rand_vec();
      case ($urandom_range(0, 3))
        0:       write_mask = '0;
        1:       write_mask = '1;
        default: write_mask = NL'($urandom);
      endcase
      clear_req    = ($urandom_range(0, 39) == 0);
      clear_strand = SW'($urandom_range(0, NS-1));
      tick();
    end
    write_en = 1'b0; clear_req = 1'b0;
    if (clear_busy) run_until_done(100);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
